psk_modulator: RTL

PSK_MODULATOR -- requirements
Module: psk_modulator

---
 rtl/psk_pkg.sv | 39 +++
 rtl/psk_modulator_if.sv | 29 ++
 rtl/psk_sine_lut.sv | 45 ++++
 rtl/psk_modulator.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/psk_pkg.sv
// Shared defaults, mode encoding, sequencer states and the symbol-to-phase mapping
// for the PSK modulator.
package psk_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int WAVELENGTH_DEF  = 16;
    localparam int PACKET_SIZE_DEF = 128;

    typedef enum logic {
        MODE_BPSK = 1'b0,
        MODE_QPSK = 1'b1
    } psk_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } psk_state_e;

    // Carrier offset in samples; QPSK walks the circle in Gray order 00,01,11,10.
    function automatic int unsigned symbol_offset(psk_mode_e mode, logic b_msb, logic b_lsb,
                                                  int unsigned wl);
        int unsigned q;
        int unsigned res;
        q = wl / 4;
        res = 0;
        if (mode == MODE_BPSK) begin
            res = b_msb ? 2 * q : 0;
        end else begin
            case ({b_msb, b_lsb})
                2'b00:   res = 0;
                2'b01:   res = q;
                2'b11:   res = 2 * q;
                default: res = 3 * q;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/psk_modulator_if.sv
// Packet-write, control and sample-output bundle of the PSK modulator.
interface psk_modulator_if import psk_pkg::*; #(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int PACKET_SIZE = PACKET_SIZE_DEF
);
    localparam int AW = $clog2(PACKET_SIZE);

    logic                         wr_en;
    logic [AW-1:0]                wr_addr;
    logic                         wr_data;
    logic [AW:0]                  pkt_len;
    logic                         mode;
    logic                         start;
    logic                         busy;
    logic                         done;
    logic                         sample_valid;
    logic signed [DATA_WIDTH-1:0] amp;

    modport master (
        output wr_en, wr_addr, wr_data, pkt_len, mode, start,
        input  busy, done, sample_valid, amp
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, pkt_len, mode, start,
        output busy, done, sample_valid, amp
    );

endinterface

// File: rtl/psk_sine_lut.sv
// One-period sine table built from parameters at elaboration; output registered,
// and forced to zero when no sample is requested.
module psk_sine_lut import psk_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int WAVELENGTH = WAVELENGTH_DEF,
    localparam int PW = $clog2(WAVELENGTH)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         en_i,
    input  logic [PW-1:0]                index_i,
    output logic signed [DATA_WIDTH-1:0] amp_o
);

    // Symmetric rounding keeps the table within +/-(2^(N-1)-1).
    function automatic logic signed [DATA_WIDTH-1:0] sine_val(int idx);
        real pi;
        real r;
        int  v;
        pi = 3.14159265358979323846;
        r  = $itor((2 ** (DATA_WIDTH - 1)) - 1) * $sin(2.0 * pi * $itor(idx) / $itor(WAVELENGTH));
        v  = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        return DATA_WIDTH'(v);
    endfunction

    logic signed [DATA_WIDTH-1:0] rom [WAVELENGTH];
    logic signed [DATA_WIDTH-1:0] amp_q, amp_d;

    for (genvar g = 0; g < WAVELENGTH; g++) begin : g_rom
        assign rom[g] = sine_val(g);
    end

    always_comb begin
        amp_d = '0;
        if (en_i) amp_d = rom[index_i];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) amp_q <= '0;
        else          amp_q <= amp_d;
    end

    assign amp_o = amp_q;

endmodule

// File: rtl/psk_modulator.sv
// PSK modulator: 1-bit packet buffer, IDLE/SEND sequencer and registered sine LUT.
// IDLE | buffer writable, waiting for start ; SEND | one sample per clock, last cycle drains the LUT register
module psk_modulator import psk_pkg::*; #(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int WAVELENGTH     = WAVELENGTH_DEF,
    parameter int PACKET_SIZE    = PACKET_SIZE_DEF,
    parameter int SYMBOL_PERIODS = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    psk_modulator_if.slave  bus
);

    localparam int AW  = $clog2(PACKET_SIZE);
    localparam int LW  = AW + 1;
    localparam int PW  = $clog2(WAVELENGTH);
    localparam int SPW = (SYMBOL_PERIODS > 1) ? $clog2(SYMBOL_PERIODS) : 1;
    localparam logic [LW:0] ONE = (LW + 1)'(1);
    localparam logic [LW:0] TWO = (LW + 1)'(2);

    psk_state_e     state_q, state_d;
    psk_mode_e      mode_q, mode_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  bit_q, bit_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [SPW-1:0] per_q, per_d;
    logic           drain_q, drain_d;
    logic           done_q, done_d;
    logic           valid_q, valid_d;
    logic           pkt_buf_q [PACKET_SIZE];

    logic [LW:0]    bit_x, len_x, lsb_x, next_x;
    logic           b_msb, b_lsb;
    logic [PW-1:0]  offset, lut_index;
    logic signed [DATA_WIDTH-1:0] amp_w;

    always_comb begin
        bit_x     = {1'b0, bit_q};
        len_x     = {1'b0, len_q};
        lsb_x     = bit_x + ONE;
        next_x    = bit_x + ((mode_q == MODE_QPSK) ? TWO : ONE);
        b_msb     = pkt_buf_q[bit_q[AW-1:0]];
        // An odd-length QPSK packet pads the missing final LSB with 0.
        b_lsb     = (mode_q == MODE_QPSK && lsb_x < len_x) ? pkt_buf_q[lsb_x[AW-1:0]] : 1'b0;
        offset    = PW'(symbol_offset(mode_q, b_msb, b_lsb, WAVELENGTH));
        lut_index = PW'((int'(phase_q) + int'(offset)) % WAVELENGTH);
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        per_d   = per_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mode_d  = psk_mode_e'(bus.mode);
                    len_d   = bus.pkt_len;
                    bit_d   = '0;
                    phase_d = '0;
                    per_d   = '0;
                    drain_d = 1'b0;
                    if (bus.pkt_len == '0) done_d  = 1'b1;
                    else                   state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (drain_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    drain_d = 1'b0;
                end else begin
                    valid_d = 1'b1;
                    if (phase_q == PW'(WAVELENGTH - 1)) begin
                        phase_d = '0;
                        if (per_q == SPW'(SYMBOL_PERIODS - 1)) begin
                            per_d = '0;
                            bit_d = next_x[LW-1:0];
                            if (next_x >= len_x) drain_d = 1'b1;
                        end else begin
                            per_d = per_q + SPW'(1);
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_BPSK;
            len_q   <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            per_q   <= '0;
            drain_q <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            per_q   <= per_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    // Buffer has no reset so a packet survives an aborted transmission.
    always_ff @(posedge clock) begin
        if (state_q == ST_IDLE && bus.wr_en) pkt_buf_q[bus.wr_addr] <= bus.wr_data;
    end

    psk_sine_lut #(
        .DATA_WIDTH (DATA_WIDTH),
        .WAVELENGTH (WAVELENGTH)
    ) u_lut (
        .clock   (clock),
        .reset_n (reset_n),
        .en_i    (valid_d),
        .index_i (lut_index),
        .amp_o   (amp_w)
    );

    assign bus.busy         = (state_q == ST_SEND);
    assign bus.done         = done_q;
    assign bus.sample_valid = valid_q;
    assign bus.amp          = amp_w;

endmodule
